// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 memory-side blocks: OAM DMA
// sequencer states, CPU read-data source select and address-map constants.
package sm83_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  typedef enum logic [1:0] {
    RD_MEM,
    RD_DMAREG,
    RD_BLOCKED
  } cpu_rd_sel_t;

  localparam logic [15:0] HRAM_IO_BASE = 16'hFF00;
  localparam logic [7:0]  ECHO_PAGE    = 8'hE0;

  // Pages E0-FF alias down to C0-DF (echo RAM) for the DMA source.
  function automatic logic [7:0] dma_src_page(input logic [7:0] page);
    return (page >= ECHO_PAGE) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/dma_engine.sv
// OAM DMA sequencer: start delay, alternating source read / OAM write,
// byte index and the capture register that holds a read byte across stalls.
module dma_engine
  import sm83_pkg::*;
#(
  parameter logic [15:0] OAM_BASE    = 16'hFE00,
  parameter int          DMA_LEN     = 160,
  parameter int          START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src_page,
  input  logic        stall,
  input  logic [7:0]  mem_rdata,
  output logic        active,
  output logic        eng_re,
  output logic        eng_we,
  output logic [15:0] eng_addr,
  output logic [7:0]  eng_wdata
);

  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [7:0] DELAY_INIT = 8'(START_DELAY - 1);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fresh_q, fresh_d;
  logic [7:0] src_q, src_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fresh_d   = fresh_q;
    src_d     = src_q;
    byte_d    = byte_q;
    eng_re    = 1'b0;
    eng_we    = 1'b0;
    eng_addr  = '0;
    eng_wdata = '0;

    case (state_q)
      DMA_START: begin
        if (cnt_q == 8'd0) state_d = DMA_READ;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DMA_READ: begin
        eng_re   = 1'b1;
        eng_addr = {src_q, idx_q};
        if (!stall) begin
          state_d = DMA_WRITE;
          fresh_d = 1'b1;
        end
      end
      DMA_WRITE: begin
        // The bus returns the read byte only in the first WRITE cycle; a
        // stalled retry must use the copy captured at the end of that cycle.
        eng_we    = 1'b1;
        eng_addr  = 16'(OAM_BASE + {8'h00, idx_q});
        eng_wdata = fresh_q ? mem_rdata : byte_q;
        if (fresh_q) byte_d = mem_rdata;
        fresh_d = 1'b0;
        if (!stall) begin
          if (idx_q == LAST_IDX) begin
            state_d = DMA_IDLE;
            idx_d   = 8'd0;
          end else begin
            state_d = DMA_READ;
            idx_d   = idx_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    // A register write restarts from any state, discarding a pending byte.
    if (start) begin
      state_d = DMA_START;
      idx_d   = 8'd0;
      cnt_d   = DELAY_INIT;
      fresh_d = 1'b0;
      src_d   = src_page;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMA_IDLE;
      idx_q   <= 8'd0;
      cnt_q   <= 8'd0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
    end
  end

  always_ff @(posedge clk) begin
    src_q  <= src_d;
    byte_q <= byte_d;
  end

  assign active = (state_q != DMA_IDLE);

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shared-bus owner between the CPU and OAM DMA: DMA page register, address
// decode, per-cycle bus arbitration and registered CPU read-data select.
module oam_dma_arbiter
  import sm83_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          DMA_LEN      = 160,
  parameter int          START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic [7:0]  dma_page
);

  logic [7:0]  dma_page_q, dma_page_d;
  cpu_rd_sel_t rd_sel_q, rd_sel_d;

  logic        reg_hit, hram_hit, cpu_acc;
  logic        eng_start, eng_stall, eng_active, eng_re, eng_we;
  logic [15:0] eng_addr;
  logic [7:0]  eng_wdata;

  assign reg_hit   = (cpu_addr == DMA_REG_ADDR);
  assign hram_hit  = (cpu_addr >= HRAM_IO_BASE);
  assign cpu_acc   = cpu_re | cpu_we;
  assign eng_start = cpu_we & reg_hit;

  dma_engine #(
    .OAM_BASE   (OAM_BASE),
    .DMA_LEN    (DMA_LEN),
    .START_DELAY(START_DELAY)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .src_page (dma_src_page(cpu_wdata)),
    .stall    (eng_stall),
    .mem_rdata(mem_rdata),
    .active   (eng_active),
    .eng_re   (eng_re),
    .eng_we   (eng_we),
    .eng_addr (eng_addr),
    .eng_wdata(eng_wdata)
  );

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    eng_stall  = 1'b0;
    dma_page_d = dma_page_q;
    rd_sel_d   = rd_sel_q;

    if (eng_start) dma_page_d = cpu_wdata;

    if (cpu_re) begin
      if (reg_hit)                       rd_sel_d = RD_DMAREG;
      else if (eng_active && !hram_hit)  rd_sel_d = RD_BLOCKED;
      else                               rd_sel_d = RD_MEM;
    end

    // HRAM/IO traffic takes the bus during a copy; the engine freezes for it.
    if (!eng_active) begin
      if (!reg_hit) begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_re    = cpu_re;
        mem_we    = cpu_we;
      end
    end else if (cpu_acc && hram_hit && !reg_hit) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_re    = cpu_re;
      mem_we    = cpu_we;
      eng_stall = 1'b1;
    end else begin
      mem_addr  = eng_addr;
      mem_wdata = eng_wdata;
      mem_re    = eng_re;
      mem_we    = eng_we;
    end
  end

  always_comb begin
    case (rd_sel_q)
      RD_MEM:    cpu_rdata = mem_rdata;
      RD_DMAREG: cpu_rdata = dma_page_q;
      default:   cpu_rdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_page_q <= 8'hFF;
      rd_sel_q   <= RD_BLOCKED;
    end else begin
      dma_page_q <= dma_page_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  assign dma_active = eng_active;
  assign dma_page   = dma_page_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: behavioural bus memory plus a
// reference of the expected OAM copy sequence derived from the page rules.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_re, cpu_we;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [7:0]  dma_page;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .dma_active(dma_active),
    .dma_page  (dma_page)
  );

  logic [7:0]  seed;
  logic [7:0]  rd_q;
  logic [23:0] wq[$];
  int          bad_wr;
  int          n_chk;
  int          n_pass;

  // Background memory: every address holds a seeded hash of itself.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    logic [15:0] h;
    h = 16'(a * 16'd40503);
    return h[12:5] ^ seed;
  endfunction

  assign mem_rdata = rd_q;

  always @(posedge clk) begin
    if (mem_re) rd_q <= src_byte(mem_addr);
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (dma_active && mem_we && (mem_addr < 16'hFE00 ||
        (mem_addr > 16'hFE9F && mem_addr < 16'hFF00)))
      bad_wr <= bad_wr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set(input logic re, input logic we, input logic [15:0] a, input logic [7:0] d);
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected copy: byte i of the source page lands at OAM_BASE+i, in order.
  function automatic int copy_errs(input int base, input logic [7:0] page);
    int e;
    e = 0;
    if (wq.size() - base != 160) return 1;
    for (int i = 0; i < 160; i++)
      if (wq[base + i] !== {16'(16'hFE00 + i), src_byte({page, 8'(i)})}) e++;
    return e;
  endfunction

  task automatic wait_bus(input logic want_we, input logic [15:0] a, output logic found);
    found = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      set(1'b0, 1'b0, 16'h0000, 8'h00);
      if ((want_we ? mem_we : mem_re) && mem_addr == a) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_idle(output int n);
    n = 0;
    for (int t = 0; t < 1000; t++) begin
      set(1'b0, 1'b0, 16'h0000, 8'h00);
      if (!dma_active) break;
      n++;
      tick();
    end
  endtask

  initial begin
    int          n_act, base, base2, w0;
    logic        found, stall_chk, stalled;
    logic [15:0] a;
    logic [7:0]  p, q;

    n_chk = 0; n_pass = 0;
    seed = 8'($urandom);
    rst = 1'b1;
    set(1'b0, 1'b0, 16'h0000, 8'h00);
    tick(); tick(); tick();
    chk("rst_active", 32'(dma_active), 32'h0);
    chk("rst_page", 32'(dma_page), 32'hFF);
    chk("rst_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_re", 32'(mem_re), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    rst = 1'b0;
    tick();

    // Idle pass-through read
    a = 16'($urandom_range(0, 32'hFEFF));
    set(1'b1, 1'b0, a, 8'h00);
    chk("idle_addr", 32'(mem_addr), 32'(a));
    chk("idle_re", 32'(mem_re), 32'h1);
    tick();
    set(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("idle_rdata", 32'(cpu_rdata), 32'(src_byte(a)));

    // Copy from C0 with blocked CPU traffic mixed in
    set(1'b0, 1'b1, 16'hFF46, 8'hC0);
    chk("regwr_no_fwd", 32'(mem_we), 32'h0);
    tick();
    base = wq.size();
    n_act = 0;
    for (int t = 1; t < 1000; t++) begin
      case (t)
        10:      set(1'b1, 1'b0, 16'h8000, 8'h00);
        20:      set(1'b0, 1'b1, 16'hC010, 8'($urandom));
        30:      set(1'b1, 1'b0, 16'hFF46, 8'h00);
        default: set(1'b0, 1'b0, 16'h0000, 8'h00);
      endcase
      if (!dma_active) break;
      n_act++;
      if (t == 1)  chk("start_quiet", 32'(mem_re | mem_we), 32'h0);
      if (t == 20) chk("drop_wr", 32'(mem_addr == 16'hC010), 32'h0);
      tick();
      if (t == 10) chk("blocked_rd", 32'(cpu_rdata), 32'hFF);
      if (t == 30) chk("reg_rd_busy", 32'(cpu_rdata), 32'hC0);
    end
    chk("len_c0", 32'(n_act), 32'd321);
    chk("copy_c0", 32'(copy_errs(base, 8'hC0)), 32'h0);
    chk("no_stray_wr", 32'(bad_wr), 32'h0);

    // Echo page E1 with an HRAM read stalling a WRITE cycle
    set(1'b0, 1'b1, 16'hFF46, 8'hE1);
    tick();
    base = wq.size();
    n_act = 0; stalled = 1'b0; stall_chk = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      set(1'b0, 1'b0, 16'h0000, 8'h00);
      if (stall_chk) begin
        chk("hram_rdata", 32'(cpu_rdata), 32'(src_byte(16'hFF85)));
        chk("retry_wr", {15'h0, mem_we, mem_addr}, {15'h0, 1'b1, 16'hFE10});
        stall_chk = 1'b0;
      end
      if (!dma_active) break;
      n_act++;
      if (!stalled && mem_we && mem_addr == 16'hFE10) begin
        set(1'b1, 1'b0, 16'hFF85, 8'h00);
        chk("stall_addr", 32'(mem_addr), 32'hFF85);
        chk("stall_we", 32'(mem_we), 32'h0);
        stalled = 1'b1;
        stall_chk = 1'b1;
      end
      tick();
    end
    chk("stall_seen", 32'(stalled), 32'h1);
    chk("len_e1", 32'(n_act), 32'd322);
    chk("copy_e1", 32'(copy_errs(base, 8'hC1)), 32'h0);
    chk("page_e1", 32'(dma_page), 32'hE1);
    set(1'b1, 1'b0, 16'hFF46, 8'h00);
    tick();
    chk("reg_rd_e1", 32'(cpu_rdata), 32'hE1);

    // Restart at the READ of idx 50
    p = 8'($urandom_range(32'h80, 32'hDF));
    set(1'b0, 1'b1, 16'hFF46, p);
    tick();
    base = wq.size();
    wait_bus(1'b0, {p, 8'h32}, found);
    chk("restart_found", 32'(found), 32'h1);
    chk("pre_restart_wr", 32'(wq.size() - base), 32'd50);
    set(1'b0, 1'b1, 16'hFF46, 8'hD0);
    tick();
    base2 = wq.size();
    set(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("restart_no_wr", 32'(mem_we), 32'h0);
    run_idle(n_act);
    chk("len_restart", 32'(n_act), 32'd321);
    chk("copy_d0", 32'(copy_errs(base2, 8'hD0)), 32'h0);

    // Reset at the WRITE of idx 80
    p = 8'($urandom_range(32'h80, 32'hDF));
    set(1'b0, 1'b1, 16'hFF46, p);
    tick();
    wait_bus(1'b1, 16'hFE50, found);
    chk("rst_found", 32'(found), 32'h1);
    rst = 1'b1;
    tick();
    chk("midrst_re", 32'(mem_re), 32'h0);
    chk("midrst_we", 32'(mem_we), 32'h0);
    chk("midrst_page", 32'(dma_page), 32'hFF);
    chk("midrst_active", 32'(dma_active), 32'h0);
    rst = 1'b0;
    w0 = wq.size();
    for (int t = 0; t < 5; t++) tick();
    chk("post_rst_wr", 32'(wq.size() - w0), 32'h0);

    // Register write on the last WRITE: restart wins
    p = 8'($urandom_range(32'h80, 32'hDF));
    q = 8'($urandom_range(32'h80, 32'hDF));
    set(1'b0, 1'b1, 16'hFF46, p);
    tick();
    wait_bus(1'b1, 16'hFE9F, found);
    chk("last_found", 32'(found), 32'h1);
    set(1'b0, 1'b1, 16'hFF46, q);
    tick();
    base = wq.size();
    set(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("restart_wins", 32'(dma_active), 32'h1);
    run_idle(n_act);
    chk("len_final", 32'(n_act), 32'd321);
    chk("copy_final", 32'(copy_errs(base, q)), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
Owns the shared 16-bit memory bus between the sm83 core and an OAM DMA engine.
- A CPU write to the DMA register starts a DMA_LEN-byte copy from {page,8'h00} to OAM_BASE.
- While the copy runs, the block arbitrates every cycle between CPU and DMA and blocks CPU accesses outside FF00-FFFF.
- Sits between the core's memory interface and the memory/IO decode; dma_active goes to the PPU.

Parameters:
DMA_REG_ADDR, 16'hFF46, CPU-visible DMA source-page register address
OAM_BASE, 16'hFE00, DMA destination base
DMA_LEN, 160, bytes per transfer (1..256)
START_DELAY, 1, idle cycles between register write and first DMA read (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_re  in  1  CPU read strobe
cpu_we  in  1  CPU write strobe (re and we never both high)
cpu_rdata  out  8  CPU read data, valid the cycle after cpu_re
mem_addr  out  16  bus address
mem_wdata  out  8  bus write data
mem_re  out  1  bus read strobe; mem_rdata valid next cycle
mem_we  out  1  bus write strobe
mem_rdata  in  8  bus read data
dma_active  out  1  high in START/READ/WRITE
dma_page  out  8  DMA register contents

Behaviour:
- Reset: state=IDLE, dma_page=8'hFF, idx=0, dma_active=0, mem_re=mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=8'hFF.
- State machine states: IDLE, START, READ, WRITE.
- IDLE: cpu_* passes straight to mem_* combinationally; cpu_rdata=mem_rdata.
- DMA register write: cpu_we with cpu_addr==DMA_REG_ADDR.
  - Next cycle: dma_page=cpu_wdata, src_page = cpu_wdata>=8'hE0 ? cpu_wdata-8'h20 : cpu_wdata, idx=0, delay counter=START_DELAY-1, state=START.
  - The write is not forwarded to mem_*.
  - Legal in any state. Mid-transfer it restarts the copy: any pending READ data is discarded and no WRITE is issued for it.
- DMA register read: cpu_re at DMA_REG_ADDR → cpu_rdata=dma_page the next cycle, in all states.
- START: counts down; at 0 → READ.
- READ: mem_re=1, mem_addr={src_page,idx[7:0]} → WRITE.
- WRITE: mem_we=1, mem_addr=OAM_BASE+idx, mem_wdata=mem_rdata captured in a register at the end of the READ-following cycle.
  - If idx==DMA_LEN-1 → IDLE with idx=0; else idx+1 → READ.
  - One byte per 2 cycles, so the copy completes START_DELAY+2*DMA_LEN cycles after the register write.
- CPU access while dma_active:
  - Address in FF00-FFFF (HRAM/IO), non-DMA-register: CPU owns the bus that cycle. mem_* carries the CPU access and the DMA holds state and idx (stall one cycle).
  - A stall in WRITE requires the captured read byte to be held.
  - Any other address: reads return 8'hFF next cycle; writes are dropped; DMA proceeds unaffected.
- START is not stalled by CPU traffic; CPU FF00-FFFF accesses pass through there.
- Select of cpu_rdata is registered with cpu_re (source: mem, dma_page, or 8'hFF).
- Simultaneous register write and DMA completion: the restart wins.
- rst asserted mid-transfer: return to reset values next edge; no further mem_we.

Decomposition:
- sm83_pkg gains:
  - dma_state_t (DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE)
  - cpu_rd_sel_t (RD_MEM, RD_DMAREG, RD_BLOCKED)
  - constants HRAM_IO_BASE=16'hFF00, ECHO_PAGE=8'hE0
- One natural sub-module: dma_engine (START/READ/WRITE sequencer, idx, capture register). The parent holds the register, address decode and arbitration mux.

Test Plan:
- Write 8'hC0 to FF46 → after 1 idle cycle, 160 read/write pairs C000→FE00 … C09F→FE9F. dma_active falls 321 cycles after the write; OAM matches source.
- CPU reads 0x8000 during DMA → cpu_rdata=8'hFF; CPU writes 0xC010 → no mem_we to C010. FF46 readback=8'hC0 throughout.
- CPU read of FF85 during a WRITE cycle → mem_addr=FF85 that cycle, DMA byte delayed one cycle, and the correct byte still lands in OAM.
- Write 8'hE1 → source reads from C100-C19F; dma_page reads back E1.
- Restart mid-transfer at idx=50 with 8'hD0 → no write of the pending byte, transfer restarts at D000→FE00, 160 bytes total.
- Assert rst at idx=80 → all mem strobes low next cycle, dma_page=FF, dma_active=0.
